// File: rtl/scan_chain_ctrl.sv
// Scan test controller: shifts a pattern into a serial scan chain, pulses one
// capture cycle, unloads the response and compares it against a golden vector.
module scan_chain_ctrl #(
    parameter int   CHAIN_LEN = 8,
    parameter logic FILL_BIT  = 1'b0
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic [CHAIN_LEN-1:0] pattern,
    input  logic [CHAIN_LEN-1:0] expected,
    input  logic                 chain_scan_out,
    output logic                 chain_scan_enable,
    output logic                 chain_scan_in,
    output logic                 busy,
    output logic                 done,
    output logic                 pass,
    output logic [CHAIN_LEN-1:0] response
);

    localparam int CW = (CHAIN_LEN > 1) ? $clog2(CHAIN_LEN) : 1;
    localparam logic [CW-1:0] LAST_IDX = CW'(CHAIN_LEN - 1);

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_LOAD    = 3'd1,
        S_CAPTURE = 3'd2,
        S_UNLOAD  = 3'd3,
        S_DONE    = 3'd4
    } state_t;

    state_t                 state_q;
    logic [CW-1:0]          cnt_q;
    logic [CW-1:0]          cnt_nxt;
    logic [CHAIN_LEN-1:0]   pattern_q;
    logic [CHAIN_LEN-1:0]   expected_q;
    logic [CHAIN_LEN-1:0]   response_q;
    logic [CHAIN_LEN-1:0]   response_d;
    logic                   scan_en_q;
    logic                   scan_in_q;
    logic                   busy_q;
    logic                   done_q;
    logic                   pass_q;

    assign cnt_nxt = cnt_q + CW'(1);

    // Response including the bit arriving this cycle, so the last UNLOAD edge
    // can register pass from the complete vector.
    always_comb begin
        response_d = response_q;
        response_d[cnt_q] = chain_scan_out;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= S_IDLE;
            cnt_q      <= '0;
            pattern_q  <= '0;
            expected_q <= '0;
            response_q <= '0;
            scan_en_q  <= 1'b0;
            scan_in_q  <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            pass_q     <= 1'b0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    done_q    <= 1'b0;
                    scan_en_q <= 1'b0;
                    scan_in_q <= 1'b0;
                    if (start) begin
                        pattern_q  <= pattern;
                        expected_q <= expected;
                        response_q <= '0;
                        cnt_q      <= '0;
                        busy_q     <= 1'b1;
                        scan_en_q  <= 1'b1;
                        // Bit 0 goes out in the first LOAD cycle, before pattern_q is visible.
                        scan_in_q  <= pattern[0];
                        state_q    <= S_LOAD;
                    end
                end
                S_LOAD: begin
                    if (cnt_q == LAST_IDX) begin
                        cnt_q     <= '0;
                        scan_en_q <= 1'b0;
                        scan_in_q <= FILL_BIT;
                        state_q   <= S_CAPTURE;
                    end else begin
                        cnt_q     <= cnt_nxt;
                        scan_en_q <= 1'b1;
                        scan_in_q <= pattern_q[cnt_nxt];
                    end
                end
                S_CAPTURE: begin
                    cnt_q     <= '0;
                    scan_en_q <= 1'b1;
                    scan_in_q <= FILL_BIT;
                    state_q   <= S_UNLOAD;
                end
                S_UNLOAD: begin
                    response_q <= response_d;
                    if (cnt_q == LAST_IDX) begin
                        cnt_q     <= '0;
                        scan_en_q <= 1'b0;
                        scan_in_q <= 1'b0;
                        done_q    <= 1'b1;
                        pass_q    <= (response_d == expected_q);
                        state_q   <= S_DONE;
                    end else begin
                        cnt_q     <= cnt_nxt;
                        scan_in_q <= FILL_BIT;
                    end
                end
                S_DONE: begin
                    done_q    <= 1'b0;
                    busy_q    <= 1'b0;
                    scan_en_q <= 1'b0;
                    scan_in_q <= 1'b0;
                    state_q   <= S_IDLE;
                end
                default: begin
                    state_q   <= S_IDLE;
                    cnt_q     <= '0;
                    scan_en_q <= 1'b0;
                    scan_in_q <= 1'b0;
                    busy_q    <= 1'b0;
                    done_q    <= 1'b0;
                end
            endcase
        end
    end

    assign chain_scan_enable = scan_en_q;
    assign chain_scan_in     = scan_in_q;
    assign busy              = busy_q;
    assign done              = done_q;
    assign pass              = pass_q;
    assign response          = response_q;

endmodule

// File: tb/tb_scan_chain_ctrl.sv
// Bench for scan_chain_ctrl: behavioural scan chains (pass-through or
// inverting capture) at lengths 8 and 2, directed tests with fixed expectations.
module tb_scan_chain_ctrl;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  // 8-flop instance
  logic       start8;
  logic [7:0] pattern8, expected8, resp8;
  logic       sout8, en8, sin8, busy8, done8, pass8;
  logic [7:0] ch8 = 8'h00;
  logic       inv8 = 1'b0;

  // 2-flop instance
  logic       start2;
  logic [1:0] pattern2, expected2, resp2;
  logic       sout2, en2, sin2, busy2, done2, pass2;
  logic [1:0] ch2 = 2'b00;

  scan_chain_ctrl #(.CHAIN_LEN(8), .FILL_BIT(1'b0)) dut8 (
    .clk(clk), .rst(rst), .start(start8), .pattern(pattern8), .expected(expected8),
    .chain_scan_out(sout8), .chain_scan_enable(en8), .chain_scan_in(sin8),
    .busy(busy8), .done(done8), .pass(pass8), .response(resp8)
  );

  scan_chain_ctrl #(.CHAIN_LEN(2), .FILL_BIT(1'b1)) dut2 (
    .clk(clk), .rst(rst), .start(start2), .pattern(pattern2), .expected(expected2),
    .chain_scan_out(sout2), .chain_scan_enable(en2), .chain_scan_in(sin2),
    .busy(busy2), .done(done2), .pass(pass2), .response(resp2)
  );

  // Chain models: flop 0 is fed by scan_in, the last flop drives scan_out.
  always @(posedge clk) begin
    if (en8) ch8 <= {ch8[6:0], sin8};
    else     ch8 <= inv8 ? ~ch8 : ch8;
  end
  assign sout8 = ch8[7];

  always @(posedge clk) begin
    if (en2) ch2 <= {ch2[0], sin2};
  end
  assign sout2 = ch2[1];

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic run8(input string tag, input logic [7:0] pat, input logic [7:0] exp_v,
                      input bit inv, input bit inj_unload, input bit inj_done,
                      input bit chg_pat, input logic [7:0] exp_resp, input bit exp_pass);
    int done_cyc;
    int en_low;
    bit busy_ok;
    logic [7:0] seq;
    @(negedge clk);
    inv8 = inv;
    pattern8 = pat;
    expected8 = exp_v;
    start8 = 1'b1;
    done_cyc = 0;
    en_low = 0;
    busy_ok = 1'b1;
    seq = '0;
    for (int c = 1; c <= 40; c++) begin
      @(negedge clk);
      start8 = 1'b0;
      if (c == 1 && chg_pat) pattern8 = 8'hFF;
      if (c <= 8) seq[c-1] = sin8;
      if (!busy8) busy_ok = 1'b0;
      if (inj_unload && c == 12) start8 = 1'b1;
      if (done8) begin
        done_cyc = c;
        if (inj_done) start8 = 1'b1;
        break;
      end
      if (!en8) en_low++;
    end
    chk({tag, "_done_cycle"}, done_cyc, 18);
    chk({tag, "_load_seq"}, seq, pat);
    chk({tag, "_en_low_cycles"}, en_low, 1);
    chk({tag, "_busy_held"}, busy_ok, 1);
    chk({tag, "_response"}, resp8, exp_resp);
    chk({tag, "_pass"}, pass8, exp_pass);
    @(negedge clk);
    start8 = 1'b0;
    chk({tag, "_busy_after"}, busy8, 0);
    chk({tag, "_done_pulse"}, done8, 0);
    chk({tag, "_resp_held"}, resp8, exp_resp);
    chk({tag, "_pass_held"}, pass8, exp_pass);
    @(negedge clk);
    chk({tag, "_no_restart"}, busy8, 0);
  endtask

  initial begin
    int done_seen;
    int done_cyc;
    int en_low;
    logic [4:0] s2;

    rst = 1'b1;
    start8 = 1'b0; pattern8 = '0; expected8 = '0;
    start2 = 1'b0; pattern2 = '0; expected2 = '0;
    #2;
    chk("rst_en", en8, 0);
    chk("rst_sin", sin8, 0);
    chk("rst_busy", busy8, 0);
    chk("rst_done", done8, 0);
    chk("rst_pass", pass8, 0);
    chk("rst_resp", resp8, 0);
    @(negedge clk);
    rst = 1'b0;

    run8("pt_a5", 8'hA5, 8'hA5, 1'b0, 1'b0, 1'b0, 1'b0, 8'hA5, 1'b1);

    // Reset asserted mid-cycle in LOAD cycle 3; outputs must clear before any edge.
    @(negedge clk);
    inv8 = 1'b0; pattern8 = 8'h5A; expected8 = 8'h5A; start8 = 1'b1;
    @(negedge clk);
    start8 = 1'b0;
    @(negedge clk);
    @(negedge clk);
    #1 rst = 1'b1;
    #1;
    chk("midrst_en", en8, 0);
    chk("midrst_busy", busy8, 0);
    chk("midrst_sin", sin8, 0);
    chk("midrst_resp", resp8, 0);
    chk("midrst_pass", pass8, 0);
    @(negedge clk);
    rst = 1'b0;
    done_seen = 0;
    for (int c = 0; c < 25; c++) begin
      @(negedge clk);
      if (done8) done_seen++;
    end
    chk("midrst_no_done", done_seen, 0);
    run8("post_rst", 8'h5A, 8'h5A, 1'b0, 1'b0, 1'b0, 1'b0, 8'h5A, 1'b1);

    run8("inv_pass", 8'h3C, 8'hC3, 1'b1, 1'b0, 1'b0, 1'b0, 8'hC3, 1'b1);
    run8("inv_fail", 8'h3C, 8'hC2, 1'b1, 1'b0, 1'b0, 1'b0, 8'hC3, 1'b0);
    run8("start_busy", 8'h96, 8'h96, 1'b0, 1'b1, 1'b1, 1'b0, 8'h96, 1'b1);
    run8("pat_change", 8'h01, 8'h01, 1'b0, 1'b0, 1'b0, 1'b1, 8'h01, 1'b1);

    // Minimum length, FILL_BIT=1: cycles 1..5 drive 0,1 (LOAD), 1 (CAPTURE), 1,1 (UNLOAD).
    @(negedge clk);
    pattern2 = 2'b10; expected2 = 2'b10; start2 = 1'b1;
    done_cyc = 0; en_low = 0; s2 = '0;
    for (int c = 1; c <= 12; c++) begin
      @(negedge clk);
      start2 = 1'b0;
      if (done2) begin
        done_cyc = c;
        break;
      end
      if (c <= 5) s2[c-1] = sin2;
      if (!en2) en_low++;
    end
    chk("len2_done_cycle", done_cyc, 6);
    chk("len2_sin_seq", s2, 5'b11110);
    chk("len2_en_low", en_low, 1);
    chk("len2_response", resp2, 2'b10);
    chk("len2_pass", pass2, 1);
    @(negedge clk);
    chk("len2_busy_after", busy2, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/scan_chain_ctrl.md
Name: scan_chain_ctrl

Overview:
- Scan test controller that drives a serial scan chain built from scan-capable master-slave DFF stages.
- Runs one test as a fixed sequence: load a pattern, pulse one capture cycle, unload the response, compare it against an expected vector.
- Sits directly upstream of the chain, driving scan_enable and scan_in. It also terminates the chain by consuming scan_out.

Parameters:
- CHAIN_LEN, 8, number of flops in the attached chain (legal range 2..256)
- FILL_BIT, 1'b0, value driven on chain_scan_in during unload

Ports:
- clk  input  1  system clock; the chain shifts or captures once per clk rising edge
- rst  input  1  asynchronous, active-high reset
- start  input  1  single-cycle request to run one test; sampled only in IDLE
- pattern  input  CHAIN_LEN  stimulus vector, latched on accepted start
- expected  input  CHAIN_LEN  golden response, latched on accepted start
- chain_scan_out  input  1  serial output of the last chain flop
- chain_scan_enable  output  1  1 = shift mode, 0 = functional capture
- chain_scan_in  output  1  serial data into the first chain flop
- busy  output  1  high from the accepted start until DONE exits
- done  output  1  one-cycle pulse when the result is valid
- pass  output  1  response == expected; valid from done, held until the next accepted start
- response  output  CHAIN_LEN  unloaded chain contents; held until the next accepted start

Behaviour:
- Reset, asynchronous, effective in any state:
  - state=IDLE, chain_scan_enable=0, chain_scan_in=0, busy=0, done=0, pass=0
  - response=0, bit counter=0, internal pattern/expected copies=0
- Reset mid-test aborts immediately. Chain contents are then undefined. No done pulse is produced.
- The FSM and all outputs are registered. Every transition happens on a clk rising edge.
- State IDLE:
  - chain_scan_enable=0, busy=0
  - start=1 latches pattern and expected, clears the counter, sets busy=1, and moves to LOAD.
  - pass and response keep their previous values until that same edge clears response.
- State LOAD, exactly CHAIN_LEN cycles:
  - chain_scan_enable=1
  - chain_scan_in = pattern_q[k] in LOAD cycle k (k=0..CHAIN_LEN-1), so pattern bit 0 is shifted first.
  - chain_scan_out is ignored.
  - When counter==CHAIN_LEN-1, move to CAPTURE.
- State CAPTURE, exactly 1 cycle:
  - chain_scan_enable=0, chain_scan_in=FILL_BIT
  - The chain loads its functional D inputs. Go to UNLOAD with the counter cleared.
- State UNLOAD, exactly CHAIN_LEN cycles:
  - chain_scan_enable=1, chain_scan_in=FILL_BIT
  - On each rising edge in UNLOAD cycle k, response[k] <= chain_scan_out.
  - The first bit out lands in response[0]. With a pass-through capture, response==pattern.
  - When counter==CHAIN_LEN-1, move to DONE.
- State DONE, 1 cycle:
  - done=1
  - pass = (response == expected_q), computed from the fully registered response and registered on entry to DONE.
  - chain_scan_enable=0, then return to IDLE with busy=0.
- Latency: start accepted at edge 0 → done high in cycle 2*CHAIN_LEN+2. busy is high for 2*CHAIN_LEN+2 cycles.
- start while busy is ignored: no queueing, no restart. A start in the same cycle done=1 is also ignored, because the FSM is not in IDLE. Back-to-back tests therefore have at least one IDLE cycle between them.
- Counter width is clog2(CHAIN_LEN). The counter wraps only through the explicit clear at each state exit and never free-runs.
- pattern and expected may change freely after acceptance. Only the latched copies are used.
- chain_scan_out is X-tolerant outside UNLOAD. It is never sampled there.

Test Plan:
- Reset mid-LOAD (rst at cycle 3 of LOAD): all outputs return to their reset values immediately and asynchronously. No done pulse. A later start runs a full 18-cycle test normally.
- Pass-through chain model (CHAIN_LEN=8, capture copies each flop's own value), pattern=8'hA5, expected=8'hA5:
  - LOAD drives scan_in sequence 1,0,1,0,0,1,0,1.
  - chain_scan_enable is low for exactly one cycle.
  - done arrives 18 cycles after start, with response=8'hA5 and pass=1.
- Inverting capture model, pattern=8'h3C, expected=8'hC3: response=8'hC3, pass=1. Repeat with expected=8'hC2: pass=0 and response unchanged.
- start pulsed during UNLOAD, and again in the cycle done=1:
  - Both are ignored and pattern is not re-latched.
  - The test completes once, and busy drops after DONE.
- pattern changed to 8'hFF one cycle after start=1 with pattern=8'h01 (pass-through model): response=8'h01. Changing the input after acceptance has no effect.
- CHAIN_LEN=2, FILL_BIT=1, pattern=2'b10, pass-through model:
  - done arrives 6 cycles after start, with response=2'b10.
  - chain_scan_in=1 throughout UNLOAD.
  - Counter boundaries are correct at the minimum legal length.
